// File: rtl/dispatch_pkg.sv
// Shared defaults and arbitration-mode constants for the slice dispatcher.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dispatch_pkg;

  // Default slice field widths as produced by the slice queue
  localparam int DEF_NUM_PARSER = 6;
  localparam int DEF_DATA_W     = 144;
  localparam int DEF_POS_W      = 16;
  localparam int DEF_ADDR_W     = 17;
  localparam int DEF_GARB_W     = 3;
  localparam int DEF_CNT_W      = 16;

  // Arbitration modes
  localparam int MODE_RR    = 0;  // round-robin, base rotates past each grant
  localparam int MODE_FIXED = 1;  // lowest-index ready parser always wins

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first req bit at or above the one-hot base, wrapping to bit 0.
// Latency: purely combinational.
// Backpressure: none; grant is zero when req is zero.
module rr_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] base,
  output logic [WIDTH-1:0] grant
);

  logic [2*WIDTH-1:0] req2;
  logic [2*WIDTH-1:0] base2;
  logic [2*WIDTH-1:0] diff2;
  logic [2*WIDTH-1:0] gnt2;

  // Subtracting the base from the doubled request clears the first request bit
  // at or above the base; the upper copy covers the wrap-around search.
  always_comb begin
    req2  = {req, req};
    base2 = {{WIDTH{1'b0}}, base};
    diff2 = req2 - base2;
    gnt2  = req2 & ~diff2;
    grant = gnt2[WIDTH-1:0] | gnt2[2*WIDTH-1:WIDTH];
  end

endmodule

// File: rtl/slice_dispatcher.sv
// Pops slices from a show-ahead queue into one output slot and hands each to a parser.
// Latency: head popped in cycle t is granted in cycle t+1 at the earliest; 1 slice/cycle sustained.
// Backpressure: slot holds while no parser is ready or stop_q is set; rdreq only when slot frees.
module slice_dispatcher
  import dispatch_pkg::*;
#(
  parameter int                    NUM_PARSER = DEF_NUM_PARSER,
  parameter int                    DATA_W     = DEF_DATA_W,
  parameter int                    POS_W      = DEF_POS_W,
  parameter int                    ADDR_W     = DEF_ADDR_W,
  parameter int                    GARB_W     = DEF_GARB_W,
  parameter logic [NUM_PARSER-1:0] BASE_INIT  = NUM_PARSER'(1),
  parameter int                    MODE       = MODE_RR,
  parameter int                    CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [POS_W-1:0]      position_in,
  input  logic [ADDR_W-1:0]     address_in,
  input  logic [GARB_W-1:0]     garbage_in,
  input  logic                  lit_flag_in,
  input  logic                  valid_in,
  output logic                  rdreq,
  input  logic                  stop,
  input  logic [NUM_PARSER-1:0] ready,
  output logic [DATA_W-1:0]     data_out,
  output logic [POS_W-1:0]      position_out,
  output logic [ADDR_W-1:0]     address_out,
  output logic [GARB_W-1:0]     garbage_out,
  output logic                  lit_flag_out,
  output logic [NUM_PARSER-1:0] valid_out,
  output logic                  slot_full,
  output logic [CNT_W-1:0]      dispatch_cnt
);

  // Slot and control state
  logic                  slot_v_q, slot_v_d;
  logic                  stop_q, stop_d;
  logic [NUM_PARSER-1:0] base_q, base_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Slot payload
  logic [DATA_W-1:0]     data_q, data_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [GARB_W-1:0]     garb_q, garb_d;
  logic                  lit_q, lit_d;

  // Arbitration and handshake
  logic [NUM_PARSER-1:0] rr_grant;
  logic [NUM_PARSER-1:0] fx_grant;
  logic [NUM_PARSER-1:0] grant;
  logic                  dispatch;
  logic                  pop;

  rr_arbiter #(
    .WIDTH (NUM_PARSER)
  ) u_rr_arbiter (
    .req   (ready),
    .base  (base_q),
    .grant (rr_grant)
  );

  // Pick the parser and decide whether the slot drains and/or refills this cycle.
  // rdreq is held low during reset so the queue head is never popped into a slot being cleared.
  always_comb begin
    fx_grant = ready & (~ready + NUM_PARSER'(1));
    grant    = (MODE == MODE_FIXED) ? fx_grant : rr_grant;
    dispatch = slot_v_q & ~stop_q & (|ready);
    pop      = rst_n & valid_in & ~stop_q & (~slot_v_q | dispatch);
  end

  // Next-state: a pop replaces the slot even when it also dispatches; base only moves on a grant.
  always_comb begin
    slot_v_d = slot_v_q;
    stop_d   = stop;
    base_d   = base_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    pos_d    = pos_q;
    addr_d   = addr_q;
    garb_d   = garb_q;
    lit_d    = lit_q;
    if (pop) begin
      slot_v_d = 1'b1;
      data_d   = data_in;
      pos_d    = position_in;
      addr_d   = address_in;
      garb_d   = garbage_in;
      lit_d    = lit_flag_in;
    end else if (dispatch) begin
      slot_v_d = 1'b0;
    end
    if (dispatch) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (MODE == MODE_RR) begin
        base_d = {grant[NUM_PARSER-2:0], grant[NUM_PARSER-1]};
      end
    end
  end

  // State registers; reset drops any held slice and restarts arbitration at BASE_INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v_q <= 1'b0;
      stop_q   <= 1'b0;
      base_q   <= BASE_INIT;
      cnt_q    <= '0;
      data_q   <= '0;
      pos_q    <= '0;
      addr_q   <= '0;
      garb_q   <= '0;
      lit_q    <= 1'b0;
    end else begin
      slot_v_q <= slot_v_d;
      stop_q   <= stop_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      pos_q    <= pos_d;
      addr_q   <= addr_d;
      garb_q   <= garb_d;
      lit_q    <= lit_d;
    end
  end

  // Outputs: payload straight from the slot, grant only pulses on a dispatch.
  always_comb begin
    rdreq        = pop;
    valid_out    = dispatch ? grant : '0;
    slot_full    = slot_v_q;
    dispatch_cnt = cnt_q;
    data_out     = data_q;
    position_out = pos_q;
    address_out  = addr_q;
    garbage_out  = garb_q;
    lit_flag_out = lit_q;
  end

endmodule

// File: tb/tb_slice_dispatcher.sv
// Bench for slice_dispatcher: three instances (round-robin, fixed priority, 4-bit counter).
// Latency: checks every cycle at the falling edge against a queue-level model.
// Backpressure: exercised through ready, stop and an empty queue.
module tb_slice_dispatcher;

  typedef struct packed {
    logic [143:0] d;
    logic [15:0]  p;
    logic [16:0]  a;
    logic [2:0]   g;
    logic         l;
  } slice_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [143:0] data_in;
  logic [15:0]  position_in;
  logic [16:0]  address_in;
  logic [2:0]   garbage_in;
  logic         lit_flag_in;
  logic         valid_in;
  logic         stop;
  logic [5:0]   ready;

  logic         rdq   [3];
  logic [5:0]   vo    [3];
  logic         sf    [3];
  logic [143:0] dout  [3];
  logic [15:0]  pout  [3];
  logic [16:0]  aout  [3];
  logic [2:0]   gout  [3];
  logic         lout  [3];
  logic [15:0]  cnt0, cnt1;
  logic [3:0]   cnt2;
  logic [15:0]  cnt_all [3];

  assign cnt_all[0] = cnt0;
  assign cnt_all[1] = cnt1;
  assign cnt_all[2] = {12'd0, cnt2};

  always #5 clk = ~clk;

  slice_dispatcher #(.NUM_PARSER(6), .BASE_INIT(6'b000001), .MODE(0), .CNT_W(16)) dut_rr (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .position_in(position_in),
    .address_in(address_in), .garbage_in(garbage_in), .lit_flag_in(lit_flag_in),
    .valid_in(valid_in), .rdreq(rdq[0]), .stop(stop), .ready(ready),
    .data_out(dout[0]), .position_out(pout[0]), .address_out(aout[0]),
    .garbage_out(gout[0]), .lit_flag_out(lout[0]), .valid_out(vo[0]),
    .slot_full(sf[0]), .dispatch_cnt(cnt0));

  slice_dispatcher #(.NUM_PARSER(6), .BASE_INIT(6'b000001), .MODE(1), .CNT_W(16)) dut_fx (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .position_in(position_in),
    .address_in(address_in), .garbage_in(garbage_in), .lit_flag_in(lit_flag_in),
    .valid_in(valid_in), .rdreq(rdq[1]), .stop(stop), .ready(ready),
    .data_out(dout[1]), .position_out(pout[1]), .address_out(aout[1]),
    .garbage_out(gout[1]), .lit_flag_out(lout[1]), .valid_out(vo[1]),
    .slot_full(sf[1]), .dispatch_cnt(cnt1));

  slice_dispatcher #(.NUM_PARSER(6), .BASE_INIT(6'b000001), .MODE(0), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .position_in(position_in),
    .address_in(address_in), .garbage_in(garbage_in), .lit_flag_in(lit_flag_in),
    .valid_in(valid_in), .rdreq(rdq[2]), .stop(stop), .ready(ready),
    .data_out(dout[2]), .position_out(pout[2]), .address_out(aout[2]),
    .garbage_out(gout[2]), .lit_flag_out(lout[2]), .valid_out(vo[2]),
    .slot_full(sf[2]), .dispatch_cnt(cnt2));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  slice_t fifo[$];
  slice_t m_slot;
  bit     m_slot_v;
  bit     m_stop_q;
  int     m_base [3];
  int     m_cnt  [3];
  int     k_mode [3] = '{0, 1, 0};
  int     k_cntw [3] = '{16, 16, 4};

  function automatic bit e_disp();
    return m_slot_v && !m_stop_q && (ready != 6'd0);
  endfunction

  function automatic bit e_rdreq();
    return rst_n && valid_in && !m_stop_q && (!m_slot_v || e_disp());
  endfunction

  // Index of the parser that should win for instance k, -1 if none ready.
  function automatic int e_gidx(int k);
    for (int i = 0; i < 6; i++) begin
      int idx;
      idx = (k_mode[k] == 1) ? i : (m_base[k] + i) % 6;
      if (ready[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [5:0] e_vo(int k);
    if (!e_disp()) return 6'd0;
    return 6'b000001 << e_gidx(k);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_slot_v <= 1'b0;
      m_slot   <= '0;
      m_stop_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_base[k] <= 0;
        m_cnt[k]  <= 0;
      end
    end else begin
      if (e_disp()) begin
        for (int k = 0; k < 3; k++) begin
          if (k_mode[k] == 0) m_base[k] <= (e_gidx(k) + 1) % 6;
          m_cnt[k] <= (m_cnt[k] + 1) % (1 << k_cntw[k]);
        end
      end
      if (e_rdreq()) begin
        m_slot   <= fifo[0];
        m_slot_v <= 1'b1;
        void'(fifo.pop_front());
      end else if (e_disp()) begin
        m_slot_v <= 1'b0;
      end
      m_stop_q <= stop;
    end
  end

  // Compare every instance against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("rdreq%0d", k), 160'(rdq[k]), 160'(e_rdreq()));
        check($sformatf("valid_out%0d", k), 160'(vo[k]), 160'(e_vo(k)));
        check($sformatf("slot_full%0d", k), 160'(sf[k]), 160'(m_slot_v));
        check($sformatf("dispatch_cnt%0d", k), 160'(cnt_all[k]), 160'(m_cnt[k]));
        check($sformatf("data_out%0d", k), 160'(dout[k]), 160'(m_slot.d));
        check($sformatf("position_out%0d", k), 160'(pout[k]), 160'(m_slot.p));
        check($sformatf("address_out%0d", k), 160'(aout[k]), 160'(m_slot.a));
        check($sformatf("garbage_out%0d", k), 160'(gout[k]), 160'(m_slot.g));
        check($sformatf("lit_flag_out%0d", k), 160'(lout[k]), 160'(m_slot.l));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] seq = 8'd1;

  function automatic slice_t mk(input logic [7:0] s);
    slice_t r;
    r.d = {18{s}};
    r.p = {8'h5A, s};
    r.a = {1'b1, s, ~s};
    r.g = s[2:0];
    r.l = s[0];
    return r;
  endfunction

  task automatic drive_head();
    slice_t h;
    h = (fifo.size() > 0) ? fifo[0] : '0;
    valid_in    = (fifo.size() > 0);
    data_in     = h.d;
    position_in = h.p;
    address_in  = h.a;
    garbage_in  = h.g;
    lit_flag_in = h.l;
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      fifo.push_back(mk(seq));
      seq = seq + 8'd1;
    end
    drive_head();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_head();
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fifo.size() == 0 && !m_slot_v) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check({name, "_drain_done"}, 160'(done), 160'(1));
  endtask

  logic [5:0]  t1_exp [7] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
                               6'b010000, 6'b100000, 6'b000001};
  logic [5:0]  g_list [$];
  logic [5:0]  g_raise;
  logic [15:0] cnt_before;
  logic [7:0]  held_seq;
  slice_t      held;
  int          n_fx;

  initial begin
    rst_n = 1'b0;
    stop  = 1'b0;
    ready = 6'b111111;
    drive_head();
    #1 chk_en = 1'b1;

    // Test 1: reset state with a full queue, then a full rotation.
    push(8);
    @(negedge clk);
    check("rst_rdreq", 160'(rdq[0]), 160'(0));
    check("rst_valid_out", 160'(vo[0]), 160'(0));
    check("rst_slot_full", 160'(sf[0]), 160'(0));
    check("rst_cnt", 160'(cnt0), 160'(0));
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("t1_rdreq_c%0d", c), 160'(rdq[0]), 160'(1));
      if (c >= 1) check($sformatf("t1_grant_c%0d", c), 160'(vo[0]), 160'(t1_exp[c-1]));
      tick();
    end
    drain("t1");

    // Test 2: two ready parsers alternate.
    ready = 6'b100100;
    cnt_before = cnt0;
    g_list.delete();
    push(4);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (vo[0] != 6'd0) g_list.push_back(vo[0]);
      tick();
    end
    check("t2_grant_count", 160'(g_list.size()), 160'(4));
    for (int i = 0; i < 4 && i < g_list.size(); i++)
      check($sformatf("t2_grant%0d", i), 160'(g_list[i]), 160'((i % 2 == 0) ? 6'b000100 : 6'b100000));
    check("t2_cnt_delta", 160'(cnt0 - cnt_before), 160'(4));
    @(negedge clk);
    check("t2_slot_empty", 160'(sf[0]), 160'(0));
    tick();

    // Test 3: no parser ready with a full slot, then a single one.
    ready = 6'b000000;
    held_seq = seq;
    held = mk(held_seq);
    push(2);
    @(negedge clk);
    check("t3_fill_rdreq", 160'(rdq[0]), 160'(1));
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("t3_hold_vo_c%0d", c), 160'(vo[0]), 160'(0));
      check($sformatf("t3_hold_rdreq_c%0d", c), 160'(rdq[0]), 160'(0));
      check($sformatf("t3_hold_data_c%0d", c), 160'(dout[0]), 160'(held.d));
      tick();
    end
    ready = 6'b000010;
    @(negedge clk);
    check("t3_release_grant", 160'(vo[0]), 160'(6'b000010));
    check("t3_release_rdreq", 160'(rdq[0]), 160'(1));
    tick();
    ready = 6'b111111;
    drain("t3");

    // Test 4: stop raised mid-stream.
    push(10);
    for (int c = 0; c < 4; c++) tick();
    stop = 1'b1;
    @(negedge clk);
    g_raise = vo[0];
    check("t4_raise_dispatch", 160'(g_raise != 6'd0), 160'(1));
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t4_stop_vo_c%0d", c), 160'(vo[0]), 160'(0));
      check($sformatf("t4_stop_rdreq_c%0d", c), 160'(rdq[0]), 160'(0));
      check($sformatf("t4_stop_slot_c%0d", c), 160'(sf[0]), 160'(1));
      tick();
    end
    stop = 1'b0;
    @(negedge clk);
    check("t4_fall_vo", 160'(vo[0]), 160'(0));
    tick();
    @(negedge clk);
    check("t4_resume_grant", 160'(vo[0]), 160'({g_raise[4:0], g_raise[5]}));
    tick();
    drain("t4");

    // Test 5: fixed priority picks the lowest ready parser.
    ready = 6'b011010;
    n_fx = 0;
    push(3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (vo[1] != 6'd0) begin
        n_fx++;
        check($sformatf("t5_fixed_grant%0d", n_fx), 160'(vo[1]), 160'(6'b000010));
      end
      tick();
    end
    check("t5_fixed_count", 160'(n_fx), 160'(3));
    ready = 6'b111111;
    drain("t5");

    // Test 6: counter wrap after a clean reset, then async reset mid-stream.
    rst_n = 1'b0;
    #1;
    check("t6_rst_cnt", 160'(cnt2), 160'(0));
    tick();
    rst_n = 1'b1;
    push(17);
    drain("t6");
    check("t6_cnt4_wrap", 160'(cnt2), 160'(1));
    check("t6_cnt16", 160'(cnt0), 160'(17));
    push(6);
    for (int c = 0; c < 3; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t6_async_slot%0d", k), 160'(sf[k]), 160'(0));
      check($sformatf("t6_async_vo%0d", k), 160'(vo[k]), 160'(0));
      check($sformatf("t6_async_rdreq%0d", k), 160'(rdq[k]), 160'(0));
    end
    held = fifo[0];
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_restart_rdreq", 160'(rdq[0]), 160'(1));
    tick();
    @(negedge clk);
    check("t6_base_reset_rr", 160'(vo[0]), 160'(6'b000001));
    check("t6_base_reset_c4", 160'(vo[2]), 160'(6'b000001));
    check("t6_head_kept", 160'(dout[0]), 160'(held.d));
    tick();
    drain("t6b");

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slice_dispatcher.md
Name: slice_dispatcher

Overview:
- Parametrised next-generation slice distributor between the slice queue (show-ahead FIFO) and NUM_PARSER second-level parsers.
- Registers one slice in an output slot, which decouples the FIFO read from parser selection.
- Selects the target parser by round-robin with post-grant rotation (MODE=0) or fixed priority (MODE=1).
- Supports a registered stop/hold and exposes per-block dispatch statistics.

Parameters:
- NUM_PARSER, 6, number of parser channels (≥2).
- DATA_W, 144, slice data width.
- POS_W, 16, position field width.
- ADDR_W, 17, address field width.
- GARB_W, 3, garbage field width.
- BASE_INIT, 1, one-hot initial arbiter base (must have exactly one bit set).
- MODE, 0, 0 = round-robin rotating, 1 = fixed priority from bit 0.
- CNT_W, 16, dispatch counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- data_in  in  DATA_W  slice data from FIFO head.
- position_in  in  POS_W  slice position.
- address_in  in  ADDR_W  slice address.
- garbage_in  in  GARB_W  garbage byte count.
- lit_flag_in  in  1  literal flag.
- valid_in  in  1  FIFO non-empty; head fields valid.
- rdreq  out  1  FIFO pop, show-ahead; combinational.
- stop  in  1  hold request; registered internally.
- ready  in  NUM_PARSER  per-parser can-accept.
- data_out  out  DATA_W  slot data (registered).
- position_out  out  POS_W  slot position.
- address_out  out  ADDR_W  slot address.
- garbage_out  out  GARB_W  slot garbage.
- lit_flag_out  out  1  slot literal flag.
- valid_out  out  NUM_PARSER  one-hot grant, one-cycle pulse per slice.
- slot_full  out  1  output slot occupied.
- dispatch_cnt  out  CNT_W  slices dispatched since reset, wraps.

Behaviour:
- Reset (async assert, sync release):
  - slot_v=0, stop_q=0, base=BASE_INIT, dispatch_cnt=0, all payload registers 0.
  - Outputs: valid_out=0, rdreq=0.
- Reset mid-operation discards the held slice; the FIFO head is untouched.
- stop_q <= stop each cycle, so stop takes effect one cycle after assertion.
- Dispatch:
  - dispatch = slot_v & ~stop_q & |ready.
  - valid_out = dispatch ? grant : 0.
  - grant is one-hot and always a subset of ready.
- Fill:
  - rdreq = valid_in & ~stop_q & (~slot_v | dispatch).
  - On rdreq, the slot loads all *_in fields at the next edge and slot_v becomes 1.
  - Otherwise, if dispatch, slot_v becomes 0.
  - Otherwise the slot holds.
- Latency and throughput:
  - A FIFO head popped in cycle t can be dispatched in cycle t+1 at the earliest.
  - Sustained throughput is 1 slice/cycle while ready≠0 and valid_in=1.
- Simultaneous dispatch and fill in one cycle are legal; the slot is replaced, not emptied.
- Payload outputs always reflect slot contents and are stable while slot_v=1 and no dispatch occurs.
- Arbitration, MODE=0:
  - Priority starts at the base bit, searching upward with wrap to bit 0.
  - On dispatch, base <= grant rotated left by 1 (the bit after the granted one).
  - With no dispatch, base holds.
- Arbitration, MODE=1: lowest-index ready bit wins; base is unused.
- Only ready at the dispatch cycle matters. A parser dropping ready while the slot is full causes no grant to it; the slot waits.
- stop_q=1:
  - No dispatch, no rdreq; the slot and base hold.
  - Deassertion resumes on the cycle after stop falls.
- dispatch_cnt increments by 1 per dispatch and wraps at 2^CNT_W−1 → 0.
- Empty FIFO (valid_in=0) with a full slot: the slot still dispatches and slot_v falls.

Decomposition:
- Package dispatch_pkg:
  - Default widths DATA_W/POS_W/ADDR_W/GARB_W.
  - MODE_RR=0, MODE_FIXED=1 constants.
- Sub-module rr_arbiter (WIDTH, req, base one-hot, grant one-hot):
  - Combinational double-width mask-subtract search.
  - Exactly one grant bit, or zero when req=0.
- Everything else lives in slice_dispatcher.

Test Plan:
1. Reset with valid_in=1, ready=6'b111111, MODE=0, BASE_INIT=1:
   - First rdreq in cycle 0 after reset release; valid_out in cycle 1 = 000001.
   - Then 000010, 000100 … 100000, 000001, one per cycle.
   - rdreq stays 1 every cycle.
2. ready=6'b100100 constant, 4 slices queued:
   - Grants alternate 000100, 100000, 000100, 100000.
   - dispatch_cnt=4; slot_full=0 after the last grant.
3. ready=0 for 5 cycles with slot full:
   - valid_out=0 and rdreq=0 throughout; data_out unchanged.
   - ready=000010 then yields a grant of 000010 on the same cycle.
4. stop raised during streaming:
   - One more dispatch occurs in the raise cycle, then valid_out=0 and rdreq=0.
   - The slot is held; after stop falls, dispatch resumes one cycle later with the next rotated parser.
5. MODE=1, ready=6'b011010, 3 slices → all grants are 000010.
6. CNT_W=4, 17 dispatches → dispatch_cnt=1.
   - Async rst_n pulse mid-stream: slot_full=0, valid_out=0 immediately, base back to 000001.
